// File: rtl/out_buf_reader.sv
// Drains the accumulator BRAM one byte per valid/ready transfer, with optional clear-after-read.
// Latency: 3 cycles per word before its first byte, plus 1 clear cycle per word when clear_en is set.
module out_buf_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int BRAM_WIDTH     = 32,
    parameter int BRAM_ADDR_BIT  = 32,
    parameter int BRAM_BYTE      = BRAM_WIDTH / 8,
    parameter int NO_ENTRY_BIT   = 16,
    parameter int NO_CHANNEL_BIT = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NO_ENTRY_BIT-1:0]   no_entry,
    input  logic [NO_CHANNEL_BIT-1:0] no_channel,
    input  logic                      clear_en,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [BRAM_ADDR_BIT-1:0]  BRAM_addr,
    output logic                      BRAM_clk,
    output logic [BRAM_WIDTH-1:0]     BRAM_din,
    input  logic [BRAM_WIDTH-1:0]     BRAM_dout,
    output logic                      BRAM_en,
    output logic                      BRAM_rst,
    output logic [BRAM_BYTE-1:0]      BRAM_wen
);

    localparam int TOT_W  = NO_ENTRY_BIT + NO_CHANNEL_BIT;
    localparam int LANE_W = $clog2(BRAM_BYTE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_CAPTURE,
        S_EMIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [TOT_W-1:0]         total_in;
    logic [TOT_W-1:0]         total_reg;
    logic [TOT_W-1:0]         byte_cnt;
    logic [BRAM_ADDR_BIT-1:0] word_addr;
    logic [LANE_W-1:0]        lane;
    logic [BRAM_WIDTH-1:0]    word_reg;
    logic                     clear_reg;
    logic                     last_byte;
    logic                     word_end;
    logic                     finished;

    assign BRAM_clk = clk;
    assign BRAM_en  = 1'b1;
    assign BRAM_rst = 1'b0;

    assign total_in  = TOT_W'(no_entry) * TOT_W'(no_channel);
    assign last_byte = (byte_cnt == total_reg - TOT_W'(1));
    assign word_end  = (lane == LANE_W'(BRAM_BYTE - 1)) || last_byte;
    // In CLEAR the byte counter has already stepped past the final byte
    assign finished  = (byte_cnt == total_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (total_in != '0) ? S_RD_ADDR : S_DONE;
                end
            end
            S_RD_ADDR: state_nxt = S_RD_WAIT;
            S_RD_WAIT: state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_EMIT;
            S_EMIT: begin
                if (m_ready && word_end) begin
                    if (clear_reg) begin
                        state_nxt = S_CLEAR;
                    end else if (last_byte) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RD_ADDR;
                    end
                end
            end
            S_CLEAR:   state_nxt = finished ? S_DONE : S_RD_ADDR;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE) && (state != S_DONE);
        done     = (state == S_DONE);
        m_valid  = (state == S_EMIT);
        m_last   = 1'b0;
        m_data   = '0;
        BRAM_din = '0;
        BRAM_wen = '0;
        if (state == S_EMIT) begin
            m_last = last_byte;
            for (int i = 0; i < BRAM_BYTE; i++) begin
                if (lane == LANE_W'(i)) begin
                    m_data = word_reg[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        // Whole word is zeroed, including unused lanes of a partial final word
        if (state == S_CLEAR) begin
            BRAM_wen = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_reg <= '0;
            clear_reg <= 1'b0;
            byte_cnt  <= '0;
            word_addr <= '0;
            lane      <= '0;
            word_reg  <= '0;
            BRAM_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        total_reg <= total_in;
                        clear_reg <= clear_en;
                        word_addr <= '0;
                        byte_cnt  <= '0;
                        lane      <= '0;
                    end
                end
                S_RD_ADDR: begin
                    BRAM_addr <= word_addr;
                end
                S_CAPTURE: begin
                    word_reg <= BRAM_dout;
                    lane     <= '0;
                end
                S_EMIT: begin
                    if (m_ready) begin
                        byte_cnt <= byte_cnt + TOT_W'(1);
                        lane     <= lane + LANE_W'(1);
                        if (word_end && !clear_reg && !last_byte) begin
                            word_addr <= word_addr + BRAM_ADDR_BIT'(BRAM_BYTE);
                        end
                    end
                end
                S_CLEAR: begin
                    if (!finished) begin
                        word_addr <= word_addr + BRAM_ADDR_BIT'(BRAM_BYTE);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
